// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD blocks: command bytes, FSM state
// encodings and the nibble-to-ASCII mapping.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DDRAM    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'h40;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        ADDR,
        CHAR
    } lcd_state_e;

    typedef enum logic [2:0] {
        BW_IDLE,
        BW_SETUP,
        BW_E_HIGH,
        BW_HOLD,
        BW_DONE
    } bw_state_e;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' (0x41 - 10 = 0x37).
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 write cycle: SETUP (1 cycle), E_HIGH (T_E_CYC), HOLD (command or
// clear wait), then a one-cycle done. A start during done chains the next byte.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int T_E_CYC   = 16,
    parameter int T_CMD_CYC = 2500,
    parameter int T_CLR_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int T_MAX_EC = (T_E_CYC > T_CMD_CYC) ? T_E_CYC : T_CMD_CYC;
    localparam int T_MAX    = (T_MAX_EC > T_CLR_CYC) ? T_MAX_EC : T_CLR_CYC;
    localparam int CNT_W    = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(T_E_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(T_CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(T_CLR_CYC - 1);

    bw_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] hold_last;

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        e_d       = e_q;
        rs_d      = rs_q;
        data_d    = data_q;
        long_d    = long_q;
        hold_last = long_q ? CLR_LAST : CMD_LAST;
        case (st_q)
            BW_IDLE, BW_DONE: begin
                if (start) begin
                    rs_d   = rs;
                    data_d = data;
                    long_d = long_wait;
                    cnt_d  = '0;
                    st_d   = BW_SETUP;
                end else begin
                    st_d = BW_IDLE;
                end
            end
            BW_SETUP: begin
                e_d   = 1'b1;
                cnt_d = '0;
                st_d  = BW_E_HIGH;
            end
            BW_E_HIGH: begin
                if (cnt_q == E_LAST) begin
                    e_d   = 1'b0;
                    cnt_d = '0;
                    st_d  = BW_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BW_HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    st_d  = BW_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                e_d  = 1'b0;
                st_d = BW_IDLE;
            end
        endcase
    end

    // Reset drops E immediately even mid-strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= BW_IDLE;
            cnt_q  <= '0;
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            long_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            e_q    <= e_d;
            rs_q   <= rs_d;
            data_q <= data_d;
            long_q <= long_d;
        end
    end

    assign done     = (st_q == BW_DONE);
    assign LCD_E    = e_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;

endmodule

// File: rtl/lcd_hex_bank.sv
// HD44780 16x2 driver that powers up and initialises the panel, then paints a
// bank of hex digits at a fixed line/column on each accepted load.
module lcd_hex_bank
    import lcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int LINE        = 0,
    parameter int START_COL   = 0,
    parameter int T_PWRUP_CYC = 750000,
    parameter int T_E_CYC     = 16,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic                    iCLK_50MHZ,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iDigits,
    input  logic                    iLoad,
    output logic                    oReady,
    output logic                    oInitDone,
    output logic [7:0]              LCD_DATA,
    output logic                    LCD_RS,
    output logic                    LCD_RW,
    output logic                    LCD_E,
    output logic                    LCD_ON,
    output logic                    LCD_BLON
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int PWR_W = $clog2(T_PWRUP_CYC + 1);

    localparam logic [PWR_W-1:0] PWR_LAST   = PWR_W'(T_PWRUP_CYC - 1);
    localparam logic [3:0]       LAST_DIGIT = 4'(NUM_DIGITS - 1);
    localparam logic [7:0]       ADDR_CMD   =
        LCD_DDRAM | (((LINE != 0) ? LCD_LINE2 : 8'h00) + 8'(START_COL));

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || START_COL < 0 || START_COL + NUM_DIGITS > 16) begin : g_bad_cfg
        $error("lcd_hex_bank: digit bank does not fit on a 16-column line");
    end

    lcd_state_e       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;

    logic       wr_start;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_long;
    logic       wr_done;
    logic [5:0] nib_shift;
    logic [3:0] nib;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        pwr_cnt_d   = pwr_cnt_q;
        digits_d    = digits_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        wr_start    = 1'b0;
        wr_rs       = 1'b0;
        wr_data     = 8'h00;
        wr_long     = 1'b0;
        nib_shift   = '0;
        nib         = '0;

        case (state_q)
            PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    idx_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (iLoad) begin
                    digits_d = iDigits;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = ADDR;
                end
            end
            INIT, ADDR, CHAR: begin
                if (!busy_q) begin
                    wr_start = 1'b1;
                    busy_d   = 1'b1;
                end else if (wr_done) begin
                    // Advance during the done cycle so the next SETUP follows immediately.
                    case (state_q)
                        INIT: begin
                            if (idx_q == 4'd3) begin
                                idx_d       = '0;
                                init_done_d = 1'b1;
                                state_d     = ADDR;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        ADDR: begin
                            idx_d   = '0;
                            state_d = CHAR;
                        end
                        default: begin
                            if (idx_q == LAST_DIGIT) begin
                                ready_d = 1'b1;
                                state_d = IDLE;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                    endcase
                    if (state_d == IDLE) begin
                        busy_d = 1'b0;
                    end else begin
                        wr_start = 1'b1;
                    end
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase

        case (state_d)
            INIT: begin
                case (idx_d)
                    4'd0:    wr_data = LCD_FUNC_SET;
                    4'd1:    wr_data = LCD_DISP_ON;
                    4'd2: begin
                        wr_data = LCD_CLEAR;
                        wr_long = 1'b1;
                    end
                    default: wr_data = LCD_ENTRY;
                endcase
            end
            ADDR: begin
                wr_data = ADDR_CMD;
            end
            CHAR: begin
                nib_shift = {LAST_DIGIT - idx_d, 2'b00};
                nib       = 4'(digits_q >> nib_shift);
                wr_rs     = 1'b1;
                wr_data   = hex_to_ascii(nib);
            end
            default: begin
                wr_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= PWRUP;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            pwr_cnt_q   <= '0;
            digits_q    <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            pwr_cnt_q   <= pwr_cnt_d;
            digits_q    <= digits_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_bus_writer #(
        .T_E_CYC   (T_E_CYC),
        .T_CMD_CYC (T_CMD_CYC),
        .T_CLR_CYC (T_CLR_CYC)
    ) u_bus_writer (
        .clk       (iCLK_50MHZ),
        .rst_n     (iRST_N),
        .start     (wr_start),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .done      (wr_done),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_DATA  (LCD_DATA)
    );

    assign oReady    = ready_q;
    assign oInitDone = init_done_q;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = 1'b1;
    assign LCD_BLON  = 1'b1;

endmodule

// File: tb/tb_lcd_hex_bank.sv
// Scoreboard bench for lcd_hex_bank: expected LCD writes are queued as stimulus
// is applied and matched against writes captured from the bus.
module tb_lcd_hex_bank;

    localparam int NUM_DIGITS  = 4;
    localparam int LINE        = 1;
    localparam int START_COL   = 2;
    localparam int T_PWRUP_CYC = 100;
    localparam int T_E_CYC     = 4;
    localparam int T_CMD_CYC   = 20;
    localparam int T_CLR_CYC   = 60;
    localparam int BOUND       = 3000;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         fall;
    } wr_t;

    logic        clk;
    logic        iRST_N;
    logic [15:0] iDigits;
    logic        iLoad;
    logic        oReady;
    logic        oInitDone;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_E;
    logic        LCD_ON;
    logic        LCD_BLON;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    wr_t        got_q[$];
    logic [8:0] exp_q[$];

    lcd_hex_bank #(
        .NUM_DIGITS  (NUM_DIGITS),
        .LINE        (LINE),
        .START_COL   (START_COL),
        .T_PWRUP_CYC (T_PWRUP_CYC),
        .T_E_CYC     (T_E_CYC),
        .T_CMD_CYC   (T_CMD_CYC),
        .T_CLR_CYC   (T_CLR_CYC)
    ) dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (iRST_N),
        .iDigits    (iDigits),
        .iLoad      (iLoad),
        .oReady     (oReady),
        .oInitDone  (oInitDone),
        .LCD_DATA   (LCD_DATA),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_E      (LCD_E),
        .LCD_ON     (LCD_ON),
        .LCD_BLON   (LCD_BLON)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] addr_byte();
        return 8'h80 + (LINE != 0 ? 8'h40 : 8'h00) + 8'(START_COL);
    endfunction

    task automatic push_refresh(input logic [15:0] d);
        exp_q.push_back({1'b0, addr_byte()});
        for (int k = 3; k >= 0; k--) begin
            logic [3:0] n;
            n = d[4*k +: 4];
            exp_q.push_back({1'b1, ascii(n)});
        end
    endtask

    // Bus monitor: captures each E pulse and checks setup, strobe width and stability.
    initial begin : monitor
        logic       e_prev, prev_rs, unstable;
        logic [7:0] prev_data;
        int         width;
        wr_t        cur;
        e_prev = 1'b0; prev_rs = 1'b0; prev_data = 8'h00; width = 0; unstable = 1'b0;
        cur = '{rs: 1'b0, data: 8'h00, rise: 0, fall: 0};
        forever begin
            @(negedge clk);
            if (iRST_N !== 1'b1) begin
                e_prev = 1'b0;
                width  = 0;
            end else begin
                if (LCD_E === 1'b1 && !e_prev) begin
                    checks++;
                    if (LCD_DATA !== prev_data || LCD_RS !== prev_rs) begin
                        failures++;
                        $display("FAIL setup: got rs=%b data=%h at E rise, required rs=%b data=%h from SETUP",
                                 LCD_RS, LCD_DATA, prev_rs, prev_data);
                    end
                    cur.rs = LCD_RS; cur.data = LCD_DATA; cur.rise = cyc;
                    width = 1; unstable = 1'b0;
                end else if (LCD_E === 1'b1) begin
                    width++;
                    if (LCD_DATA !== cur.data || LCD_RS !== cur.rs) unstable = 1'b1;
                end else if (e_prev) begin
                    if (LCD_DATA !== cur.data || LCD_RS !== cur.rs) unstable = 1'b1;
                    cur.fall = cyc;
                    checks++;
                    if (width != T_E_CYC) begin
                        failures++;
                        $display("FAIL e_width: got %0d cycles, required %0d", width, T_E_CYC);
                    end
                    checks++;
                    if (unstable || LCD_RW !== 1'b0) begin
                        failures++;
                        $display("FAIL bus_stable: got unstable=%b rw=%b, required 0/0", unstable, LCD_RW);
                    end
                    got_q.push_back(cur);
                end
                e_prev = LCD_E; prev_data = LCD_DATA; prev_rs = LCD_RS;
            end
        end
    end

    task automatic get_write(output wr_t w, output bit ok);
        ok = 1'b0;
        w  = '{rs: 1'b0, data: 8'h00, rise: 0, fall: 0};
        for (int i = 0; i < BOUND; i++) begin
            if (got_q.size() > 0) begin
                w  = got_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (oReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; iLoad = 1'b0; iDigits = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (LCD_E !== 1'b0 || LCD_RS !== 1'b0) begin
            failures++;
            $display("FAIL reset_e_rs: got E=%b RS=%b, required 0/0", LCD_E, LCD_RS);
        end
        checks++;
        if (LCD_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h, required 00", LCD_DATA);
        end
        checks++;
        if (oReady !== 1'b0 || oInitDone !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got ready=%b init_done=%b, required 0/0", oReady, oInitDone);
        end
        checks++;
        if (LCD_RW !== 1'b0 || LCD_ON !== 1'b1 || LCD_BLON !== 1'b1) begin
            failures++;
            $display("FAIL reset_consts: got rw=%b on=%b blon=%b, required 0/1/1", LCD_RW, LCD_ON, LCD_BLON);
        end
    endtask

    task automatic test_init(input string tag);
        int  early_e;
        int  fall_clr;
        wr_t w;
        bit  ok;
        logic [8:0] exp;
        @(negedge clk);
        iRST_N = 1'b1;
        #1;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        push_refresh(16'h0000);
        early_e = 0;
        repeat (T_PWRUP_CYC) begin
            @(negedge clk); #1;
            if (LCD_E !== 1'b0) early_e++;
        end
        checks++;
        if (early_e != 0) begin
            failures++;
            $display("FAIL %s_pwrup: got %0d E-high cycles during power-up, required 0", tag, early_e);
        end
        fall_clr = 0;
        for (int i = 0; i < 9; i++) begin
            get_write(w, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_write%0d: got timeout, required rs/data %h", tag, i, exp);
            end else if ({w.rs, w.data} !== exp) begin
                failures++;
                $display("FAIL %s_write%0d: got rs/data %h, required %h", tag, i, {w.rs, w.data}, exp);
            end
            if (i == 2) fall_clr = w.fall;
            if (i == 3) begin
                checks++;
                if (w.fall - fall_clr < T_CLR_CYC + T_E_CYC) begin
                    failures++;
                    $display("FAIL %s_clear_gap: got %0d cycles, required >= %0d", tag, w.fall - fall_clr, T_CLR_CYC + T_E_CYC);
                end
                checks++;
                if (oInitDone !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_initdone_early: got %b, required 0", tag, oInitDone);
                end
            end
            if (i == 4) begin
                checks++;
                if (oInitDone !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_initdone: got %b, required 1", tag, oInitDone);
                end
            end
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_ready: got 0 after init refresh, required 1", tag);
        end
        exp_q.delete();
    endtask

    task automatic test_load();
        int  acc;
        wr_t w;
        bit  ok;
        logic [8:0] exp;
        @(negedge clk); #1;
        iDigits = 16'hA5F0;
        iLoad   = 1'b1;
        push_refresh(16'hA5F0);
        @(negedge clk); #1;
        acc   = cyc;
        iLoad = 1'b0;
        checks++;
        if (oReady !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_drop: got %b, required 0", oReady);
        end
        for (int i = 0; i < 5; i++) begin
            get_write(w, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {w.rs, w.data} !== exp) begin
                failures++;
                $display("FAIL load_write%0d: got ok=%b rs/data %h, required %h", i, ok, {w.rs, w.data}, exp);
            end
            if (i == 0) begin
                checks++;
                if (w.rise - acc != 2) begin
                    failures++;
                    $display("FAIL load_latency: got %0d cycles, required 2", w.rise - acc);
                end
            end
            if (i == 4) begin
                checks++;
                if (oReady !== 1'b0) begin
                    failures++;
                    $display("FAIL load_ready_early: got %b, required 0", oReady);
                end
            end
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL load_ready_return: got 0, required 1");
        end
    endtask

    task automatic test_ignore();
        wr_t w;
        bit  ok;
        logic [8:0] exp;
        @(negedge clk); #1;
        iDigits = 16'h9C3B;
        iLoad   = 1'b1;
        push_refresh(16'h9C3B);
        @(negedge clk); #1;
        iLoad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_write(w, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || {w.rs, w.data} !== exp) begin
                failures++;
                $display("FAIL ignore_write%0d: got ok=%b rs/data %h, required %h", i, ok, {w.rs, w.data}, exp);
            end
            if (i == 0) begin
                iDigits = 16'h1234;
                iLoad   = 1'b1;
                @(negedge clk); #1;
                iLoad = 1'b0;
                checks++;
                if (oReady !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_ready: got %b during refresh, required 0", oReady);
                end
            end
        end
        wait_ready(ok);
        repeat (60) @(negedge clk);
        #1;
        checks++;
        if (!ok || got_q.size() != 0 || LCD_E !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_requeue: got ready=%b extra_writes=%0d E=%b, required 1/0/0", ok, got_q.size(), LCD_E);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        wr_t w;
        bit  ok;
        logic [8:0] exp;
        vals[0] = 16'h0001; vals[1] = 16'hBEEF; vals[2] = 16'h7D6C;
        @(negedge clk); #1;
        iLoad = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_ready(ok);
            iDigits = vals[r];
            push_refresh(vals[r]);
            @(negedge clk); #1;
            if (r == 2) iLoad = 1'b0;
            checks++;
            if (!ok || oReady !== 1'b0) begin
                failures++;
                $display("FAIL b2b_accept%0d: got ready_seen=%b ready_after=%b, required 1/0", r, ok, oReady);
            end
            for (int i = 0; i < 5; i++) begin
                get_write(w, ok);
                exp = exp_q.pop_front();
                checks++;
                if (!ok || {w.rs, w.data} !== exp) begin
                    failures++;
                    $display("FAIL b2b_r%0d_write%0d: got ok=%b rs/data %h, required %h", r, i, ok, {w.rs, w.data}, exp);
                end
            end
        end
        wait_ready(ok);
    endtask

    task automatic test_async_reset();
        bit ok;
        @(negedge clk); #1;
        iDigits = 16'h7777;
        iLoad   = 1'b1;
        @(negedge clk); #1;
        iLoad = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (LCD_E === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        #2;
        iRST_N = 1'b0;
        #1;
        checks++;
        if (!ok || LCD_E !== 1'b0 || oInitDone !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got e_seen=%b E=%b init_done=%b, required 1/0/0", ok, LCD_E, oInitDone);
        end
        repeat (3) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        test_init("reinit");
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_init("init");
        test_load();
        test_ignore();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
